// File: rtl/euc_ctrl_monitor.sv
// Per-channel ap_ctrl handshake monitor: counts starts/completions, tracks latency,
// stall cycles, protocol errors and timeouts, with a registered readout port.
module euc_ctrl_monitor #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024,
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              finish,
    input  logic              rd_req,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_start_cnt,
    output logic [CNT_W-1:0]  rd_done_cnt,
    output logic [CNT_W-1:0]  rd_last_lat,
    output logic [CNT_W-1:0]  rd_max_lat,
    output logic [CNT_W-1:0]  rd_stall_cnt,
    output logic [5:0]        rd_status,
    output logic              all_idle
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;

    localparam int CMP_W = (CNT_W > 32) ? CNT_W : 32;
    localparam logic [CMP_W-1:0] TMO_LIM = CMP_W'(TIMEOUT);

    state_t           state_q [NUM_CH];
    state_t           state_d [NUM_CH];
    logic [CNT_W-1:0] lat_q   [NUM_CH];
    logic [CNT_W-1:0] lat_d   [NUM_CH];
    logic [CNT_W-1:0] start_q [NUM_CH];
    logic [CNT_W-1:0] start_d [NUM_CH];
    logic [CNT_W-1:0] done_q  [NUM_CH];
    logic [CNT_W-1:0] done_d  [NUM_CH];
    logic [CNT_W-1:0] last_q  [NUM_CH];
    logic [CNT_W-1:0] last_d  [NUM_CH];
    logic [CNT_W-1:0] max_q   [NUM_CH];
    logic [CNT_W-1:0] max_d   [NUM_CH];
    logic [CNT_W-1:0] stall_q [NUM_CH];
    logic [CNT_W-1:0] stall_d [NUM_CH];
    logic [NUM_CH-1:0] err_q, err_d, tmo_q, tmo_d;
    logic [NUM_CH-1:0] accept, retire;
    logic frozen_q, frozen_d, all_idle_q, all_idle_d;

    logic             sel_hit, sel_err, sel_tmo;
    state_t           sel_state;
    logic [CNT_W-1:0] sel_start, sel_done, sel_last, sel_max, sel_stall;

    logic             rd_valid_q;
    logic [CNT_W-1:0] rd_start_q, rd_done_q, rd_last_q, rd_max_q, rd_stall_q;
    logic [5:0]       rd_status_q;

    assign accept = ap_start & ap_ready;
    assign retire = ap_done & ap_continue;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        frozen_d = frozen_q | finish;
        err_d    = err_q;
        tmo_d    = tmo_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            lat_d[i]   = lat_q[i];
            start_d[i] = start_q[i];
            done_d[i]  = done_q[i];
            last_d[i]  = last_q[i];
            max_d[i]   = max_q[i];
            stall_d[i] = stall_q[i];
            if (!frozen_q) begin
                // A restart while BUSY/HOLD only bumps the start count.
                if (accept[i]) start_d[i] = sat_inc(start_q[i]);
                case (state_q[i])
                    IDLE: begin
                        if (accept[i]) begin
                            if (retire[i]) begin
                                done_d[i] = sat_inc(done_q[i]);
                                last_d[i] = '0;
                            end else if (ap_done[i]) begin
                                last_d[i]  = '0;
                                state_d[i] = HOLD;
                            end else begin
                                lat_d[i]   = CNT_W'(1);
                                state_d[i] = BUSY;
                            end
                        end else if (ap_done[i]) begin
                            err_d[i] = 1'b1;
                        end
                    end
                    BUSY: begin
                        if (CMP_W'(lat_q[i]) >= TMO_LIM) tmo_d[i] = 1'b1;
                        if (ap_done[i]) begin
                            last_d[i] = lat_q[i];
                            if (lat_q[i] > max_q[i]) max_d[i] = lat_q[i];
                            if (ap_continue[i]) begin
                                done_d[i]  = sat_inc(done_q[i]);
                                state_d[i] = IDLE;
                            end else begin
                                state_d[i] = HOLD;
                            end
                        end else begin
                            lat_d[i] = sat_inc(lat_q[i]);
                        end
                    end
                    HOLD: begin
                        if (ap_continue[i]) begin
                            done_d[i]  = sat_inc(done_q[i]);
                            state_d[i] = IDLE;
                        end else begin
                            stall_d[i] = sat_inc(stall_q[i]);
                        end
                    end
                    default: state_d[i] = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        all_idle_d = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (state_d[i] != IDLE) all_idle_d = 1'b0;
        end
    end

    // Readout reflects this edge's update, so select from next-state values.
    always_comb begin
        sel_hit   = 1'b0;
        sel_err   = 1'b0;
        sel_tmo   = 1'b0;
        sel_state = IDLE;
        sel_start = '0;
        sel_done  = '0;
        sel_last  = '0;
        sel_max   = '0;
        sel_stall = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                sel_hit   = 1'b1;
                sel_err   = err_d[i];
                sel_tmo   = tmo_d[i];
                sel_state = state_d[i];
                sel_start = start_d[i];
                sel_done  = done_d[i];
                sel_last  = last_d[i];
                sel_max   = max_d[i];
                sel_stall = stall_d[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                lat_q[i]   <= '0;
                start_q[i] <= '0;
                done_q[i]  <= '0;
                last_q[i]  <= '0;
                max_q[i]   <= '0;
                stall_q[i] <= '0;
            end
            err_q       <= '0;
            tmo_q       <= '0;
            frozen_q    <= 1'b0;
            all_idle_q  <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_start_q  <= '0;
            rd_done_q   <= '0;
            rd_last_q   <= '0;
            rd_max_q    <= '0;
            rd_stall_q  <= '0;
            rd_status_q <= '0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            start_q    <= start_d;
            done_q     <= done_d;
            last_q     <= last_d;
            max_q      <= max_d;
            stall_q    <= stall_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            frozen_q   <= frozen_d;
            all_idle_q <= all_idle_d;
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_start_q  <= sel_start;
                rd_done_q   <= sel_done;
                rd_last_q   <= sel_last;
                rd_max_q    <= sel_max;
                rd_stall_q  <= sel_stall;
                rd_status_q <= {~sel_hit, frozen_d, sel_err, sel_tmo, sel_state};
            end
        end
    end

    assign rd_valid     = rd_valid_q;
    assign rd_start_cnt = rd_start_q;
    assign rd_done_cnt  = rd_done_q;
    assign rd_last_lat  = rd_last_q;
    assign rd_max_lat   = rd_max_q;
    assign rd_stall_cnt = rd_stall_q;
    assign rd_status    = rd_status_q;
    assign all_idle     = all_idle_q;

endmodule

// File: tb/tb_euc_ctrl_monitor.sv
// Bench for euc_ctrl_monitor: directed scenarios plus random handshakes checked
// against an unbounded-count reference model clipped at the counter ceiling.
module tb_euc_ctrl_monitor;

    localparam int NCH  = 3;
    localparam int CW   = 4;
    localparam int TMO  = 8;
    localparam int SATV = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [NCH-1:0] ap_start = '0, ap_ready = '0, ap_done = '0, ap_continue = '0;
    logic          finish = 1'b0;
    logic          rd_req = 1'b0;
    logic [1:0]    rd_sel = '0;
    logic          rd_valid;
    logic [CW-1:0] rd_start_cnt, rd_done_cnt, rd_last_lat, rd_max_lat, rd_stall_cnt;
    logic [5:0]    rd_status;
    logic          all_idle;

    euc_ctrl_monitor #(.NUM_CH(NCH), .CNT_W(CW), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .finish(finish), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_valid(rd_valid), .rd_start_cnt(rd_start_cnt), .rd_done_cnt(rd_done_cnt),
        .rd_last_lat(rd_last_lat), .rd_max_lat(rd_max_lat), .rd_stall_cnt(rd_stall_cnt),
        .rd_status(rd_status), .all_idle(all_idle)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: true (unbounded) counts; saturation applied when reporting.
    int m_start [NCH], m_done [NCH], m_last [NCH], m_max [NCH], m_stall [NCH], m_lat [NCH];
    bit m_busy [NCH], m_hold [NCH], m_err [NCH], m_tmo [NCH];
    bit m_frozen;
    logic          e_valid;
    logic [CW-1:0] e_start, e_done, e_last, e_max, e_stall;
    logic [5:0]    e_status;

    function automatic logic [CW-1:0] clip(input int v);
        return (v > SATV) ? CW'(SATV) : CW'(v);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) begin
            m_start[i] = 0; m_done[i] = 0; m_last[i] = 0; m_max[i] = 0;
            m_stall[i] = 0; m_lat[i] = 0;
            m_busy[i] = 0; m_hold[i] = 0; m_err[i] = 0; m_tmo[i] = 0;
        end
        m_frozen = 0;
        e_valid = 0; e_start = '0; e_done = '0; e_last = '0; e_max = '0; e_stall = '0;
        e_status = '0;
    endtask

    task automatic model_step();
        if (!m_frozen) begin
            for (int i = 0; i < NCH; i++) begin
                bit acc, ret;
                acc = ap_start[i] && ap_ready[i];
                ret = ap_done[i] && ap_continue[i];
                if (acc) m_start[i]++;
                if (m_hold[i]) begin
                    if (ap_continue[i]) begin m_done[i]++; m_hold[i] = 0; end
                    else m_stall[i]++;
                end else if (m_busy[i]) begin
                    if (m_lat[i] >= TMO) m_tmo[i] = 1;
                    if (ap_done[i]) begin
                        m_last[i] = m_lat[i];
                        if (m_lat[i] > m_max[i]) m_max[i] = m_lat[i];
                        m_busy[i] = 0;
                        if (ap_continue[i]) m_done[i]++;
                        else m_hold[i] = 1;
                    end else begin
                        m_lat[i]++;
                    end
                end else if (acc) begin
                    if (ret) begin m_done[i]++; m_last[i] = 0; end
                    else if (ap_done[i]) begin m_last[i] = 0; m_hold[i] = 1; end
                    else begin m_lat[i] = 1; m_busy[i] = 1; end
                end else if (ap_done[i]) begin
                    m_err[i] = 1;
                end
            end
        end
        if (finish) m_frozen = 1;
        e_valid = rd_req;
        if (rd_req) begin
            if (int'(rd_sel) < NCH) begin
                int s;
                s = int'(rd_sel);
                e_start = clip(m_start[s]);
                e_done  = clip(m_done[s]);
                e_last  = clip(m_last[s]);
                e_max   = clip(m_max[s]);
                e_stall = clip(m_stall[s]);
                e_status = {1'b0, m_frozen, m_err[s], m_tmo[s],
                            m_hold[s] ? 2'd2 : (m_busy[s] ? 2'd1 : 2'd0)};
            end else begin
                e_start = '0; e_done = '0; e_last = '0; e_max = '0; e_stall = '0;
                e_status = {1'b1, m_frozen, 4'b0000};
            end
        end
    endtask

    task automatic check_outputs();
        bit idle;
        idle = 1;
        for (int i = 0; i < NCH; i++) if (m_busy[i] || m_hold[i]) idle = 0;
        check_eq("all_idle", all_idle, idle);
        check_eq("rd_valid", rd_valid, e_valid);
        check_eq("rd_start", rd_start_cnt, e_start);
        check_eq("rd_done", rd_done_cnt, e_done);
        check_eq("rd_last", rd_last_lat, e_last);
        check_eq("rd_max", rd_max_lat, e_max);
        check_eq("rd_stall", rd_stall_cnt, e_stall);
        check_eq("rd_status", rd_status, e_status);
    endtask

    task automatic cycle(input logic [NCH-1:0] st, input logic [NCH-1:0] rdy,
                         input logic [NCH-1:0] dn, input logic [NCH-1:0] cn,
                         input logic fin, input logic rq, input logic [1:0] sel);
        ap_start = st; ap_ready = rdy; ap_done = dn; ap_continue = cn;
        finish = fin; rd_req = rq; rd_sel = sel;
        @(posedge clock);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) cycle('0, '0, '0, '0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic read_ch(input logic [1:0] sel);
        cycle('0, '0, '0, '0, 1'b0, 1'b1, sel);
    endtask

    // Reset is raised between edges to exercise its asynchronous clear.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_outputs();
        ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '0;
        finish = 1'b0; rd_req = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        model_clear();
        #1 reset = 1'b1;
        #1 check_outputs();
        @(posedge clock);
        #2 reset = 1'b0;

        // Single transaction, latency 5
        do_reset();
        cycle(3'b001, 3'b001, '0, '0, 1'b0, 1'b0, 2'd0);
        idle_cycles(4);
        cycle('0, '0, 3'b001, 3'b001, 1'b0, 1'b1, 2'd0);
        check_eq("t30_start", rd_start_cnt, 1);
        check_eq("t30_done", rd_done_cnt, 1);
        check_eq("t30_last", rd_last_lat, 5);
        check_eq("t30_max", rd_max_lat, 5);
        check_eq("t30_state", rd_status[1:0], 0);

        // Done with back-pressure: 4 stall cycles
        do_reset();
        cycle(3'b010, 3'b010, '0, '0, 1'b0, 1'b0, 2'd0);
        idle_cycles(2);
        cycle('0, '0, 3'b010, '0, 1'b0, 1'b0, 2'd0);
        idle_cycles(4);
        cycle('0, '0, '0, 3'b010, 1'b0, 1'b1, 2'd1);
        check_eq("t31_stall", rd_stall_cnt, 4);
        check_eq("t31_last", rd_last_lat, 3);
        check_eq("t31_done", rd_done_cnt, 1);

        // Timeout on ch0, ch1 untouched
        do_reset();
        cycle(3'b001, 3'b001, '0, '0, 1'b0, 1'b0, 2'd0);
        idle_cycles(10);
        read_ch(2'd0);
        check_eq("t32_ch0_status", rd_status, 6'b000101);
        read_ch(2'd1);
        check_eq("t32_ch1_status", rd_status, 6'b000000);

        // Spurious done, then same-cycle accept+retire
        do_reset();
        cycle('0, '0, 3'b001, '0, 1'b0, 1'b1, 2'd0);
        check_eq("t33_err", rd_status, 6'b001000);
        check_eq("t33_start0", rd_start_cnt, 0);
        cycle(3'b001, 3'b001, 3'b001, 3'b001, 1'b0, 1'b1, 2'd0);
        check_eq("t33_start", rd_start_cnt, 1);
        check_eq("t33_done", rd_done_cnt, 1);
        check_eq("t33_last", rd_last_lat, 0);

        // Freeze, then bad select
        do_reset();
        cycle(3'b001, 3'b001, 3'b001, 3'b001, 1'b0, 1'b0, 2'd0);
        cycle('0, '0, '0, '0, 1'b1, 1'b0, 2'd0);
        cycle(3'b001, 3'b001, '0, '0, 1'b0, 1'b0, 2'd0);
        cycle('0, '0, 3'b001, 3'b001, 1'b0, 1'b0, 2'd0);
        read_ch(2'd0);
        check_eq("t34_start", rd_start_cnt, 1);
        check_eq("t34_frozen", rd_status[4], 1);
        read_ch(2'd3);
        check_eq("t34_selerr", rd_status, 6'b110000);
        check_eq("t34_data0", rd_done_cnt, 0);

        // Saturation at 15, then reset mid-BUSY
        do_reset();
        repeat (20) cycle(3'b100, 3'b100, 3'b100, 3'b100, 1'b0, 1'b0, 2'd0);
        read_ch(2'd2);
        check_eq("t35_start", rd_start_cnt, 15);
        check_eq("t35_done", rd_done_cnt, 15);
        cycle(3'b001, 3'b001, '0, '0, 1'b0, 1'b0, 2'd0);
        check_eq("t35_busy", all_idle, 0);
        do_reset();
        check_eq("t35_idle", all_idle, 1);
        read_ch(2'd0);
        check_eq("t35_clr_start", rd_start_cnt, 0);
        check_eq("t35_clr_status", rd_status, 0);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic [NCH-1:0] st, rdy, dn, cn;
            if ($urandom_range(0, 199) == 0) do_reset();
            st  = NCH'($urandom);
            rdy = NCH'($urandom);
            cn  = NCH'($urandom);
            for (int i = 0; i < NCH; i++) dn[i] = ($urandom_range(0, 3) == 0);
            cycle(st, rdy, dn, cn, ($urandom_range(0, 299) == 0),
                  1'($urandom), 2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
